fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter N, default 32: PC and instruction width in bits.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset; asserted when 0.
REQ-005 stall  input  1: decode stage cannot accept; hold the delivered instruction.
REQ-006 flush  input  1: discard the delivered instruction; PC unchanged.
REQ-007 jmp_req  input  1: redirect request from a later stage.
REQ-008 jmp_target  input  N: redirect address.
REQ-009 imem_ack  input  1: instruction memory returns data this cycle.
REQ-010 imem_rdata  input  N: instruction word, valid when imem_ack=1.
REQ-011 imem_req  output  1: fetch request to instruction memory.
REQ-012 imem_addr  output  N: fetch address, equals pc while imem_req=1.
REQ-013 pc  output  N: address of the instruction currently being fetched.
REQ-014 instr  output  N: registered instruction delivered to decode.
REQ-015 instr_pc  output  N: address of instr.
REQ-016 instr_valid  output  1: instr/instr_pc are valid.
REQ-017 misalign  output  1: one-cycle pulse when jmp_target[1:0]!=0.

Function
REQ-018 The FSM SHALL have states BOOT, FETCH, HOLD and DRAIN.
REQ-019 BOOT: imem_req=0; unconditional transition to FETCH next cycle.
REQ-020 FETCH: imem_req=1, imem_addr=pc; the request SHALL stay asserted with a stable address until imem_ack.
REQ-021 FETCH with imem_ack and no jmp_req: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (mod 2^N, wraps silently); next state HOLD if stall, else FETCH.
REQ-022 HOLD: imem_req=0; instr, instr_pc and instr_valid stable; transition to FETCH when stall=0.
REQ-023 Throughput: with imem_ack=1 every cycle and stall=0, one instruction SHALL be delivered per cycle.
REQ-024 An instruction SHALL be consumed by decode on any cycle with instr_valid=1 and stall=0; with no new ack that cycle, instr_valid<=0.
REQ-025 jmp_req (highest priority, any state except BOOT): pc<=jmp_target with bits [1:0] forced to 0; instr_valid<=0; misalign pulses if jmp_target[1:0]!=0.
REQ-026 jmp_req in FETCH without imem_ack: next state DRAIN; DRAIN holds imem_req=0 (request already issued), discards the data on the next imem_ack, then enters FETCH at the new pc.
REQ-027 jmp_req coinciding with imem_ack: the returned data SHALL be discarded; next state FETCH.
REQ-028 flush without jmp_req: instr_valid<=0; pc and FSM state unaffected, except HOLD->FETCH; flush overrides stall.
REQ-029 Simultaneous jmp_req and flush SHALL behave as jmp_req alone.

Reset
REQ-030 While reset=0: state=BOOT, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, imem_req=0, misalign=0.
REQ-031 Reset assertion mid-transaction SHALL abandon any outstanding request immediately; no data is captured.

Configuration
REQ-032 Macro FETCH_CTRL_PERF_EN defined: adds outputs perf_fetch_cnt[31:0] (delivered instructions) and perf_stall_cnt[31:0] (cycles in HOLD or DRAIN); both cleared by reset, saturating at 2^32-1.
REQ-033 Macro undefined: the counters and their ports SHALL be absent; all other behaviour identical.

Structure
REQ-034 Package fetch_pkg SHALL hold the state enum type fetch_state_t and the constant PC_STEP=4.
REQ-035 Sub-module fetch_pc_reg SHALL hold the PC register with load (redirect) and increment enables and the RESET_PC reset value.

Verification
REQ-036 Reset release, imem_ack=1 every cycle -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles after one BOOT cycle; instr_valid high from the cycle after the first ack.
REQ-037 stall=1 for 3 cycles after the instr at 0x8 is delivered -> instr_pc held at 0x8, imem_req=0; fetch resumes at 0xC.
REQ-038 jmp_req with target 0x100 while FETCH waits (imem_ack=0) -> DRAIN; the next ack's data is dropped; the next request is at 0x100.
REQ-039 jmp_req with target 0x203 -> misalign pulses for 1 cycle; the next fetch is at 0x200.
REQ-040 pc=0xFFFF_FFFC with an ack -> pc wraps to 0x0000_0000.
REQ-041 reset asserted while imem_req=1 -> all outputs return to reset values asynchronously, before the next clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction memory request/acknowledge bus between fetch_ctrl and imem.
interface fetch_ctrl_if #(
    parameter int N = 32
);
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_ack;
    logic [N-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter register: redirect load has priority over the sequential increment.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         inc,
    input  logic [N-1:0] load_value,
    output logic [N-1:0] pc
);

    logic [N-1:0] pc_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg <= RESET_PC;
        end else if (load) begin
            pc_reg <= load_value;
        end else if (inc) begin
            pc_reg <= pc_reg + N'(PC_STEP);
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: BOOT/FETCH/HOLD/DRAIN sequencing, redirect and flush.
// Define FETCH_CTRL_PERF_EN to add saturating fetch/stall performance counters.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                jmp_req,
    input  logic [N-1:0]        jmp_target,
    fetch_ctrl_if.master        imem,
    output logic [N-1:0]        pc,
    output logic [N-1:0]        instr,
    output logic [N-1:0]        instr_pc,
    output logic                instr_valid,
    output logic                misalign
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    fetch_state_t state_reg;
    logic [N-1:0] instr_reg;
    logic [N-1:0] instr_pc_reg;
    logic         instr_valid_reg;
    logic         imem_req_reg;
    logic         misalign_reg;

    logic         redirect;
    logic         deliver;
    logic [N-1:0] aligned_target;

    // A flush on the ack cycle drops the returned word, so the same pc is refetched.
    assign redirect       = jmp_req && (state_reg != BOOT);
    assign deliver        = (state_reg == FETCH) && imem.imem_ack && !jmp_req && !flush;
    assign aligned_target = {jmp_target[N-1:2], 2'b00};

    fetch_pc_reg #(
        .N        (N),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (redirect),
        .inc        (deliver),
        .load_value (aligned_target),
        .pc         (pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= BOOT;
            instr_reg       <= '0;
            instr_pc_reg    <= '0;
            instr_valid_reg <= 1'b0;
            imem_req_reg    <= 1'b0;
            misalign_reg    <= 1'b0;
        end else begin
            misalign_reg <= redirect && (jmp_target[1:0] != 2'b00);
            case (state_reg)
                BOOT: begin
                    instr_valid_reg <= 1'b0;
                    state_reg       <= FETCH;
                    imem_req_reg    <= 1'b1;
                end
                FETCH: begin
                    if (jmp_req) begin
                        instr_valid_reg <= 1'b0;
                        // Without the ack the request is still in flight and must be drained.
                        if (!imem.imem_ack) begin
                            state_reg    <= DRAIN;
                            imem_req_reg <= 1'b0;
                        end
                    end else if (flush) begin
                        instr_valid_reg <= 1'b0;
                    end else if (imem.imem_ack) begin
                        instr_reg       <= imem.imem_rdata;
                        instr_pc_reg    <= pc;
                        instr_valid_reg <= 1'b1;
                        if (stall) begin
                            state_reg    <= HOLD;
                            imem_req_reg <= 1'b0;
                        end
                    end else if (!stall) begin
                        instr_valid_reg <= 1'b0;
                    end
                end
                HOLD: begin
                    if (jmp_req || flush || !stall) begin
                        instr_valid_reg <= 1'b0;
                        state_reg       <= FETCH;
                        imem_req_reg    <= 1'b1;
                    end
                end
                DRAIN: begin
                    instr_valid_reg <= 1'b0;
                    if (imem.imem_ack) begin
                        state_reg    <= FETCH;
                        imem_req_reg <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign imem.imem_req  = imem_req_reg;
    assign imem.imem_addr = pc;
    assign instr          = instr_reg;
    assign instr_pc       = instr_pc_reg;
    assign instr_valid    = instr_valid_reg;
    assign misalign       = misalign_reg;

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetch_cnt_reg;
    logic [31:0] perf_stall_cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt_reg <= '0;
            perf_stall_cnt_reg <= '0;
        end else begin
            if (deliver && !(&perf_fetch_cnt_reg)) begin
                perf_fetch_cnt_reg <= perf_fetch_cnt_reg + 32'd1;
            end
            if (((state_reg == HOLD) || (state_reg == DRAIN)) && !(&perf_stall_cnt_reg)) begin
                perf_stall_cnt_reg <= perf_stall_cnt_reg + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_cnt_reg;
    assign perf_stall_cnt = perf_stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run against a flag-based model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        jmp_req = 1'b0;
    logic [31:0] jmp_target = '0;
    logic [31:0] pc, instr, instr_pc;
    logic        instr_valid, misalign;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    fetch_ctrl_if #(.N(32)) bus ();

    fetch_ctrl #(.N(32), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .jmp_req     (jmp_req),
        .jmp_target  (jmp_target),
        .imem        (bus),
        .pc          (pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .misalign    (misalign)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: what the controller is doing, described as flags rather than states.
    logic [31:0] m_pc, m_instr, m_ipc;
    logic        m_valid, m_mis;
    logic        m_boot, m_hold, m_drain;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
        m_valid = 1'b0; m_mis = 1'b0;
        m_boot = 1'b1; m_hold = 1'b0; m_drain = 1'b0;
    endtask

    task automatic model_update(input logic s, input logic f, input logic j,
                                input logic [31:0] t, input logic a, input logic [31:0] d);
        m_mis = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (j) begin
            m_mis   = (t % 4) != 0;
            m_pc    = t - (t % 4);
            m_valid = 1'b0;
            if (m_hold)       m_hold = 1'b0;
            else if (m_drain) m_drain = !a;
            else              m_drain = !a;
        end else if (m_drain) begin
            if (a) m_drain = 1'b0;
        end else if (m_hold) begin
            if (f || !s) begin
                m_valid = 1'b0;
                m_hold  = 1'b0;
            end
        end else if (f) begin
            m_valid = 1'b0;
        end else if (a) begin
            m_instr = d;
            m_ipc   = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            m_hold  = s;
        end else if (!s) begin
            m_valid = 1'b0;
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, return at the falling edge.
    task automatic step(input logic s, input logic f, input logic j,
                        input logic [31:0] t, input logic a, input logic [31:0] d);
        stall = s; flush = f; jmp_req = j; jmp_target = t;
        bus.imem_ack = a; bus.imem_rdata = d;
        @(posedge clk);
        if (reset) model_update(s, f, j, t, a, d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0;
        repeat (2) @(negedge clk);
        model_reset();
        checks++;
        if ({bus.imem_req, pc, instr, instr_pc, instr_valid, misalign} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state: req=%b pc=%h instr=%h ipc=%h v=%b mis=%b, want all zero",
                     bus.imem_req, pc, instr, instr_pc, instr_valid, misalign);
        end
    endtask

    task automatic test_boot_stream();
        logic [31:0] d;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (bus.imem_req !== 1'b0) begin
            failures++;
            $display("FAIL boot_idle: req=%b want 0", bus.imem_req);
        end
        step(0, 0, 0, 0, 1, $urandom);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL boot_first_req: req=%b addr=%h v=%b want 1/00000000/0",
                     bus.imem_req, bus.imem_addr, instr_valid);
        end
        for (int k = 0; k < 2; k++) begin
            d = $urandom;
            step(0, 0, 0, 0, 1, d);
            checks++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * (k + 1)) || instr_valid !== 1'b1 ||
                instr !== d || instr_pc !== 32'(4 * k)) begin
                failures++;
                $display("FAIL stream_%0d: req=%b addr=%h v=%b instr=%h ipc=%h want 1/%h/1/%h/%h",
                         k, bus.imem_req, bus.imem_addr, instr_valid, instr, instr_pc,
                         32'(4 * (k + 1)), d, 32'(4 * k));
            end
        end
    endtask

    task automatic test_stall_hold();
        logic [31:0] d;
        d = $urandom;
        step(1, 0, 0, 0, 1, d);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.imem_req !== 1'b0 || instr_pc !== 32'h8 || instr !== d || instr_valid !== 1'b1 || pc !== 32'hC) begin
                failures++;
                $display("FAIL stall_hold_%0d: req=%b ipc=%h instr=%h v=%b pc=%h want 0/00000008/%h/1/0000000c",
                         k, bus.imem_req, instr_pc, instr, instr_valid, pc, d);
            end
            if (k < 3) step(1, 0, 0, 0, 1, $urandom);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_resume: req=%b addr=%h v=%b want 1/0000000c/0",
                     bus.imem_req, bus.imem_addr, instr_valid);
        end
    endtask

    task automatic test_jump_drain();
        logic [31:0] d;
        step(0, 0, 1, 32'h100, 0, 0);
        checks++;
        if (bus.imem_req !== 1'b0 || pc !== 32'h100 || instr_valid !== 1'b0 || misalign !== 1'b0) begin
            failures++;
            $display("FAIL jump_drain: req=%b pc=%h v=%b mis=%b want 0/00000100/0/0",
                     bus.imem_req, pc, instr_valid, misalign);
        end
        step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_drop: req=%b addr=%h v=%b want 1/00000100/0",
                     bus.imem_req, bus.imem_addr, instr_valid);
        end
        d = $urandom;
        step(0, 0, 0, 0, 1, d);
        checks++;
        if (instr_valid !== 1'b1 || instr !== d || instr_pc !== 32'h100 || bus.imem_addr !== 32'h104) begin
            failures++;
            $display("FAIL jump_deliver: v=%b instr=%h ipc=%h addr=%h want 1/%h/00000100/00000104",
                     instr_valid, instr, instr_pc, bus.imem_addr, d);
        end
    endtask

    task automatic test_misalign();
        step(0, 0, 1, 32'h203, 0, 0);
        checks++;
        if (misalign !== 1'b1 || pc !== 32'h200) begin
            failures++;
            $display("FAIL misalign_pulse: mis=%b pc=%h want 1/00000200", misalign, pc);
        end
        step(0, 0, 0, 0, 1, $urandom);
        checks++;
        if (misalign !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin
            failures++;
            $display("FAIL misalign_fetch: mis=%b req=%b addr=%h want 0/1/00000200",
                     misalign, bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        step(0, 0, 1, 32'hFFFF_FFFC, 1, 32'h1234_5678);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL jump_with_ack: req=%b addr=%h v=%b want 1/fffffffc/0",
                     bus.imem_req, bus.imem_addr, instr_valid);
        end
        d = $urandom;
        step(0, 0, 0, 0, 1, d);
        checks++;
        if (pc !== 32'h0 || instr_pc !== 32'hFFFF_FFFC || instr !== d || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL pc_wrap: pc=%h ipc=%h instr=%h v=%b want 00000000/fffffffc/%h/1",
                     pc, instr_pc, instr, instr_valid, d);
        end
    endtask

    task automatic test_flush();
        step(1, 0, 0, 0, 1, $urandom);
        step(1, 1, 0, 0, 0, 0);
        checks++;
        if (bus.imem_req !== 1'b1 || pc !== 32'h4 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_over_stall: req=%b pc=%h v=%b want 1/00000004/0",
                     bus.imem_req, pc, instr_valid);
        end
    endtask

    task automatic test_async_reset();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({bus.imem_req, pc, instr, instr_pc, instr_valid, misalign} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL async_reset: req=%b pc=%h instr=%h ipc=%h v=%b mis=%b, want all zero before edge",
                     bus.imem_req, pc, instr, instr_pc, instr_valid, misalign);
        end
        @(negedge clk);
        model_reset();
    endtask

    task automatic test_random();
        logic        s, f, j, a;
        logic [31:0] t, d;
        reset = 1'b1;
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 9) == 0);
            j = ($urandom_range(0, 11) == 0);
            a = ($urandom_range(0, 9) < 6);
            t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            d = $urandom;
            step(s, f, j, t, a, d);
            checks++;
            if (bus.imem_req !== !(m_boot || m_hold || m_drain) || pc !== m_pc ||
                (bus.imem_req && bus.imem_addr !== m_pc) || instr_valid !== m_valid ||
                instr !== m_instr || instr_pc !== m_ipc || misalign !== m_mis) begin
                failures++;
                $display("FAIL random_%0d: req=%b pc=%h v=%b instr=%h ipc=%h mis=%b want %b/%h/%b/%h/%h/%b",
                         n, bus.imem_req, pc, instr_valid, instr, instr_pc, misalign,
                         !(m_boot || m_hold || m_drain), m_pc, m_valid, m_instr, m_ipc, m_mis);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_boot_stream();
        test_stall_hold();
        test_jump_drain();
        test_misalign();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
